// File: rtl/multi_grant_priority_picker.sv
// Registered K-of-M priority picker: fixed or round-robin scan, either direction, valid/ready output.
// Optional statistics counters are enabled by defining PICKER_STATS_EN.
module multi_grant_priority_picker #(
   parameter int unsigned M = 8,
   parameter int unsigned N = $clog2(M),
   parameter int unsigned K = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [M-1:0]   req,
   input  logic           bottom_up,
   input  logic           rr_mode,
   input  logic           out_ready,
   output logic           out_valid,
   output logic [K-1:0]   grant_valid,
   output logic [K*N-1:0] grant_idx,
`ifdef PICKER_STATS_EN
   output logic [M-1:0]   grant_mask,
   output logic [31:0]    stat_picks,
   output logic [31:0]    stat_stalls
`else
   output logic [M-1:0]   grant_mask
`endif
);

   logic [N-1:0]   ptr;
   logic [N-1:0]   ptr_next;
   logic           load;
   logic [K-1:0]   pick_valid;
   logic [K*N-1:0] pick_idx;
   logic [M-1:0]   pick_mask;

   assign load = !out_valid || out_ready;

   // Walk the M lines in scan order; the n-th set bit found fills slot n.
   // Wrap is done by a single conditional subtract so non-power-of-2 M wraps at M.
   always_comb begin
      int unsigned start;
      int unsigned line;
      int unsigned cnt;
      int unsigned last;
      logic [N-1:0] line_n;

      pick_valid = '0;
      pick_idx   = '0;
      pick_mask  = '0;
      ptr_next   = ptr;
      cnt        = 0;
      last       = 0;
      line       = 0;
      line_n     = '0;

      if (rr_mode)
         start = int'(ptr);
      else if (bottom_up)
         start = 0;
      else
         start = M - 1;

      for (int unsigned p = 0; p < M; p++) begin
         if (bottom_up)
            line = start + p;
         else
            line = start + M - p;
         if (line >= M)
            line = line - M;
         line_n = N'(line);

         if (req[line_n] && (cnt < K)) begin
            for (int unsigned j = 0; j < K; j++) begin
               if (j == cnt) begin
                  pick_valid[j]       = 1'b1;
                  pick_idx[j*N +: N]  = line_n;
               end
            end
            pick_mask[line_n] = 1'b1;
            last = line;
            cnt  = cnt + 1;
         end
      end

      if (rr_mode && (cnt != 0)) begin
         if (bottom_up)
            ptr_next = (last == M - 1) ? '0 : N'(last + 1);
         else
            ptr_next = (last == 0) ? N'(M - 1) : N'(last - 1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         grant_valid <= '0;
         grant_idx   <= '0;
         grant_mask  <= '0;
         ptr         <= '0;
      end else if (load) begin
         out_valid   <= |req;
         grant_valid <= pick_valid;
         grant_idx   <= pick_idx;
         grant_mask  <= pick_mask;
         ptr         <= ptr_next;
      end
   end

`ifdef PICKER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_picks  <= '0;
         stat_stalls <= '0;
      end else if (out_valid) begin
         if (out_ready)
            stat_picks  <= stat_picks + 32'($countones(grant_valid));
         else
            stat_stalls <= stat_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multi_grant_priority_picker.sv
// Directed-vector bench for multi_grant_priority_picker (M=8, K=2, N=3).
module tb_multi_grant_priority_picker;

   localparam int unsigned M = 8;
   localparam int unsigned N = 3;
   localparam int unsigned K = 2;

   logic           clk;
   logic           rst;
   logic [M-1:0]   req;
   logic           bottom_up;
   logic           rr_mode;
   logic           out_ready;
   logic           out_valid;
   logic [K-1:0]   grant_valid;
   logic [K*N-1:0] grant_idx;
   logic [M-1:0]   grant_mask;
`ifdef PICKER_STATS_EN
   logic [31:0]    stat_picks;
   logic [31:0]    stat_stalls;
`endif

   int unsigned errors = 0;
   int unsigned checks = 0;

   multi_grant_priority_picker #(.M(M), .N(N), .K(K)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .bottom_up  (bottom_up),
      .rr_mode    (rr_mode),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .grant_valid(grant_valid),
      .grant_idx  (grant_idx),
`ifdef PICKER_STATS_EN
      .grant_mask (grant_mask),
      .stat_picks (stat_picks),
      .stat_stalls(stat_stalls)
`else
      .grant_mask (grant_mask)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // idx argument is {idx1, idx0} packed as 3-bit fields
   task automatic expect_out(input string tag, input logic ov, input logic [1:0] gv,
                             input logic [5:0] idx, input logic [7:0] mask);
      check({tag, ".valid"}, 32'(out_valid), 32'(ov));
      check({tag, ".gv"},    32'(grant_valid), 32'(gv));
      check({tag, ".idx"},   32'(grant_idx), 32'(idx));
      check({tag, ".mask"},  32'(grant_mask), 32'(mask));
   endtask

   initial begin
      rst = 1'b1; req = '0; bottom_up = 1'b1; rr_mode = 1'b0; out_ready = 1'b1;
      tick();
      tick();
      expect_out("reset", 1'b0, 2'b00, 6'd0, 8'h00);
`ifdef PICKER_STATS_EN
      check("reset.picks",  stat_picks,  32'd0);
      check("reset.stalls", stat_stalls, 32'd0);
`endif
      rst = 1'b0;

      // fixed ascending: picks 2 then 5
      req = 8'b1010_0100; bottom_up = 1'b1; rr_mode = 1'b0;
      tick();
      expect_out("fix_up", 1'b1, 2'b11, {3'd5, 3'd2}, 8'b0010_0100);

      // stall: outputs frozen while req changes
      out_ready = 1'b0; req = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out("stall", 1'b1, 2'b11, {3'd5, 3'd2}, 8'b0010_0100);
      end
      out_ready = 1'b1;
      tick();
      expect_out("unstall", 1'b1, 2'b11, {3'd1, 3'd0}, 8'h03);

      // fixed descending: picks 7 then 5
      req = 8'b1010_0100; bottom_up = 1'b0;
      tick();
      expect_out("fix_dn", 1'b1, 2'b11, {3'd5, 3'd7}, 8'b1010_0000);

      // round-robin ascending from ptr=0 (fixed-mode loads left ptr alone)
      req = 8'hFF; bottom_up = 1'b1; rr_mode = 1'b1;
      tick(); expect_out("rr_up0", 1'b1, 2'b11, {3'd1, 3'd0}, 8'h03);
      tick(); expect_out("rr_up1", 1'b1, 2'b11, {3'd3, 3'd2}, 8'h0C);
      tick(); expect_out("rr_up2", 1'b1, 2'b11, {3'd5, 3'd4}, 8'h30);
      tick(); expect_out("rr_up3", 1'b1, 2'b11, {3'd7, 3'd6}, 8'hC0);
      tick(); expect_out("rr_up4", 1'b1, 2'b11, {3'd1, 3'd0}, 8'h03);

      // reset to bring ptr back to 0, then descending round-robin wrap
      rst = 1'b1;
      tick();
      expect_out("rst2", 1'b0, 2'b00, 6'd0, 8'h00);
      rst = 1'b0; bottom_up = 1'b0;
      tick(); expect_out("rr_dn0", 1'b1, 2'b11, {3'd7, 3'd0}, 8'h81);
      tick(); expect_out("rr_dn1", 1'b1, 2'b11, {3'd5, 3'd6}, 8'h60);

      // sparse then empty in fixed mode; ptr (now 4) must survive these loads
      rr_mode = 1'b0; bottom_up = 1'b1; req = 8'b0000_0001;
      tick(); expect_out("sparse", 1'b1, 2'b01, 6'd0, 8'h01);
      req = 8'h00;
      tick(); expect_out("empty", 1'b0, 2'b00, 6'd0, 8'h00);
      rr_mode = 1'b1;
      tick(); expect_out("empty_rr", 1'b0, 2'b00, 6'd0, 8'h00);
      req = 8'hFF;
      tick(); expect_out("rr_keep", 1'b1, 2'b11, {3'd5, 3'd4}, 8'h30);

      // single grant in round-robin: ptr advances past the lone pick (6 -> 7)
      req = 8'b0100_0000;
      tick(); expect_out("rr_one", 1'b1, 2'b01, {3'd0, 3'd6}, 8'h40);
      req = 8'b1000_0011;
      tick(); expect_out("rr_wrap", 1'b1, 2'b11, {3'd0, 3'd7}, 8'h81);

      // reset mid-stall: ptr is nonzero (1) before reset
      rr_mode = 1'b0; req = 8'b1010_0100;
      tick(); expect_out("pre_stall", 1'b1, 2'b11, {3'd5, 3'd2}, 8'b0010_0100);
      out_ready = 1'b0;
      tick();
      tick();
`ifdef PICKER_STATS_EN
      check("stalls", stat_stalls, 32'd2);
`endif
      rst = 1'b1;
      tick();
      expect_out("rst_stall", 1'b0, 2'b00, 6'd0, 8'h00);
`ifdef PICKER_STATS_EN
      check("rst.picks",  stat_picks,  32'd0);
      check("rst.stalls", stat_stalls, 32'd0);
`endif
      rst = 1'b0; out_ready = 1'b1; rr_mode = 1'b1; bottom_up = 1'b1; req = 8'hFF;
      tick(); expect_out("ptr_cleared", 1'b1, 2'b11, {3'd1, 3'd0}, 8'h03);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
